// File: rtl/pkt_fifo_ctrl_if.sv
// Ingress stream, egress stream and buffer-memory port bundle for pkt_fifo_ctrl.
// Latency: none, wiring only.
// Backpressure: carries in_ready/out_ready; slave is the controller side, master the environment side.
interface pkt_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    // ingress beat stream
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
`ifdef PKT_FIFO_ERR_DROP_EN
    logic                  in_err;
`endif
    // egress beat stream
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    // dual-port buffer memory, entries are {last, data}
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH:0]   mem_wdata;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH:0]   mem_rdata;

    modport slave (
`ifdef PKT_FIFO_ERR_DROP_EN
        input  in_err,
`endif
        input  in_valid, in_data, in_last,
        output in_ready,
        output out_valid, out_data, out_last,
        input  out_ready,
        output mem_we, mem_waddr, mem_wdata, mem_raddr,
        input  mem_rdata
    );

    modport master (
`ifdef PKT_FIFO_ERR_DROP_EN
        output in_err,
`endif
        output in_valid, in_data, in_last,
        input  in_ready,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  mem_we, mem_waddr, mem_wdata, mem_raddr,
        output mem_rdata
    );
endinterface

// File: rtl/pkt_fifo_ctrl.sv
// Store-and-forward packet FIFO controller driving a 1-cycle-read dual-port buffer memory.
// Latency: last beat accepted in cycle N -> commit at edge N, read issue N+1, out_valid N+3.
// Backpressure: in_ready drops when the memory is full; out_valid holds with stable data until out_ready.
// Optional macro PKT_FIFO_ERR_DROP_EN adds in_err: a last beat flagged with in_err drops its packet.
module pkt_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pkt_fifo_ctrl_if.slave      bus,
    output logic [ADDR_WIDTH:0] pkt_count,
    output logic                drop_pulse
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(1 << ADDR_WIDTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DISCARD} wr_state_t;

    wr_state_t     state;
    wr_state_t     state_nxt;
    logic [PW-1:0] wr_ptr;      // tentative write pointer, rewound on drop
    logic [PW-1:0] wr_commit;   // end of the last fully received packet
    logic [PW-1:0] rd_ptr;
    logic          ready_en;
    logic          full;
    logic          in_ready_c;
    logic          in_fire;
    logic          oversize;
    logic          pkt_err;
    logic          wr_en;
    logic          commit;
    logic          rewind;
    logic          drop;
    logic          out_valid;
    logic          pop;
    logic          rd_issue;
    logic          rd_pend;
    logic [1:0]    ob_cnt;
    logic [1:0]    ob_occ;
    logic          pkt_dec;
    beat_t         ob0;
    beat_t         ob1;
    beat_t         rd_beat;
    beat_t         wr_beat;

    assign full       = (wr_ptr - rd_ptr) == DEPTH_P;
    assign in_ready_c = ready_en && ((state == ST_DISCARD) || !full);
    assign in_fire    = bus.in_valid && in_ready_c;
    // Full while every stored entry belongs to the packet being written: it can never fit.
    assign oversize   = (state == ST_WRITE) && full && (wr_commit == rd_ptr);

`ifdef PKT_FIFO_ERR_DROP_EN
    assign pkt_err = bus.in_err;
`else
    assign pkt_err = 1'b0;
`endif

    // Holds in_ready low during reset; it rises after the first clock edge following release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Write FSM next-state: an oversize packet diverts to DISCARD until its last beat.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_WRITE: begin
                if (oversize)     state_nxt = ST_DISCARD;
                else if (in_fire) state_nxt = bus.in_last ? ST_IDLE : ST_WRITE;
            end
            ST_DISCARD: begin
                if (in_fire && bus.in_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write FSM outputs: memory write, commit, and rewind-with-drop decisions.
    always_comb begin
        wr_en  = 1'b0;
        commit = 1'b0;
        rewind = 1'b0;
        drop   = 1'b0;
        if (state != ST_DISCARD) begin
            if (oversize) begin
                rewind = 1'b1;
                drop   = 1'b1;
            end else if (in_fire) begin
                wr_en = 1'b1;
                if (bus.in_last) begin
                    if (pkt_err) begin
                        rewind = 1'b1;
                        drop   = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
        end
    end

    assign wr_beat       = '{last: bus.in_last, data: bus.in_data};
    assign bus.in_ready  = in_ready_c;
    assign bus.mem_we    = wr_en;
    assign bus.mem_waddr = wr_ptr[ADDR_WIDTH-1:0];
    assign bus.mem_wdata = wr_beat;
    assign drop_pulse    = drop;

    // Write pointers: advance per stored beat, snap back to the commit point on a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            wr_commit <= '0;
        end else begin
            if (rewind)     wr_ptr <= wr_commit;
            else if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (commit)     wr_commit <= wr_ptr + PTR_ONE;
        end
    end

    // Reads only touch committed entries; the beat popped this cycle frees its slot
    // immediately so the steady state sustains one beat per cycle.
    assign out_valid     = ob_cnt != 2'd0;
    assign pop           = out_valid && bus.out_ready;
    assign ob_occ        = ob_cnt + {1'b0, rd_pend} - {1'b0, pop};
    assign rd_issue      = (rd_ptr != wr_commit) && (ob_occ < 2'd2);
    assign bus.mem_raddr = rd_ptr[ADDR_WIDTH-1:0];
    assign rd_beat       = bus.mem_rdata;

    // Read pointer and the one-cycle read-in-flight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            rd_pend <= 1'b0;
        end else begin
            if (rd_issue) rd_ptr <= rd_ptr + PTR_ONE;
            rd_pend <= rd_issue;
        end
    end

    // Two-entry output buffer: ob0 is the head presented on out_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob0    <= '0;
            ob1    <= '0;
            ob_cnt <= '0;
        end else begin
            ob_cnt <= ob_occ;
            case ({rd_pend, pop})
                2'b10: begin
                    if (ob_cnt == 2'd0) ob0 <= rd_beat;
                    else                ob1 <= rd_beat;
                end
                2'b01: ob0 <= ob1;
                2'b11: begin
                    if (ob_cnt == 2'd1) begin
                        ob0 <= rd_beat;
                    end else begin
                        ob0 <= ob1;
                        ob1 <= rd_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = ob0.data;
    assign bus.out_last  = ob0.last;
    assign pkt_dec       = pop && ob0.last;

    // Committed-but-unsent packet count; simultaneous commit and last-pop cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else begin
            case ({commit, pkt_dec})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_fifo_ctrl.sv
// Self-checking bench for pkt_fifo_ctrl: cycle table for the basic packet, directed
// corner sequences, and randomized packets against a packet-level scoreboard.
// A behavioural dual-port memory with one-cycle read latency sits on the memory port.
module tb_pkt_fifo_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW:0]   pkt_count;
    logic          drop_pulse;

    always #5 clk = ~clk;

    pkt_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    pkt_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .pkt_count  (pkt_count),
        .drop_pulse (drop_pulse)
    );

    // buffer memory model
    logic [DW:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_raddr];
    end

    typedef struct packed {
        logic          iv;
        logic [DW-1:0] id;
        logic          il;
        logic          ordy;
        logic          e_irdy;
        logic          e_we;
        logic [AW-1:0] e_wa;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_ol;
        logic [AW:0]   e_pc;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [DW:0] exp_q [$];
    int          pc_model = 0;
    int          drops = 0;
    logic        sb_en = 1'b0;
    logic        cur_ok = 1'b1;
    logic        done = 1'b0;
    logic        stall_prev = 1'b0;
    logic [DW:0] held = '0;
    logic        rnd_done = 1'b0;
    vec_t        tbl [11];

    function automatic vec_t mk(int iv, int id, int il, int ordy, int irdy, int we, int wa,
                                int ov, int od, int ol, int pc);
        vec_t v;
        v.iv = iv[0]; v.id = DW'(id); v.il = il[0]; v.ordy = ordy[0];
        v.e_irdy = irdy[0]; v.e_we = we[0]; v.e_wa = AW'(wa);
        v.e_ov = ov[0]; v.e_od = DW'(od); v.e_ol = ol[0]; v.e_pc = (AW+1)'(pc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one beat and hold it until accepted; returns the write address it was offered at.
    task automatic send_beat(input logic [DW-1:0] d, input logic l, output logic [AW-1:0] wa);
        int n;
        n  = 0;
        wa = '0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) begin
                wa = bus.mem_waddr;
                break;
            end
            n++;
            if (n >= 2000) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: beat 0x%0h not accepted within 2000 cycles", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Send a whole packet of len beats base, base+1, ...; ok packets are expected at the egress.
    task automatic send_pkt(input int len, input logic [DW-1:0] base, input logic ok,
                            output logic [AW-1:0] first_wa);
        logic [AW-1:0] wa;
        cur_ok = ok;
        if (ok) begin
            for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), base + DW'(i)});
        end
        first_wa = '0;
        for (int i = 0; i < len; i++) begin
            send_beat(base + DW'(i), (i == len - 1), wa);
            if (i == 0) first_wa = wa;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain_remaining_beats", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] wa;
        logic [AW-1:0] wa2;
        int            d0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
`ifdef PKT_FIFO_ERR_DROP_EN
        bus.in_err    = 1'b0;
`endif
        rst_n = 1'b0;

        // basic 4-beat packet, cycle by cycle
        tbl[0]  = mk(1, 'h10, 0, 1,  1, 1, 0,  0, 0,    0, 0);
        tbl[1]  = mk(1, 'h11, 0, 1,  1, 1, 1,  0, 0,    0, 0);
        tbl[2]  = mk(1, 'h12, 0, 1,  1, 1, 2,  0, 0,    0, 0);
        tbl[3]  = mk(1, 'h13, 1, 1,  1, 1, 3,  0, 0,    0, 0);
        tbl[4]  = mk(0, 0,    0, 1,  1, 0, 0,  0, 0,    0, 1);
        tbl[5]  = mk(0, 0,    0, 1,  1, 0, 0,  0, 0,    0, 1);
        tbl[6]  = mk(0, 0,    0, 1,  1, 0, 0,  1, 'h10, 0, 1);
        tbl[7]  = mk(0, 0,    0, 1,  1, 0, 0,  1, 'h11, 0, 1);
        tbl[8]  = mk(0, 0,    0, 1,  1, 0, 0,  1, 'h12, 0, 1);
        tbl[9]  = mk(0, 0,    0, 1,  1, 0, 0,  1, 'h13, 1, 1);
        tbl[10] = mk(0, 0,    0, 1,  1, 0, 0,  0, 0,    0, 0);

        fork
            begin : monitor
                while (!done) begin
                    @(negedge clk);
                    if (sb_en) begin
                        chk("pkt_count_model", pkt_count, pc_model);
                        if (stall_prev) begin
                            chk("stall_out_valid", bus.out_valid, 1);
                            chk("stall_out_beat", {bus.out_last, bus.out_data}, held);
                        end
                        if (bus.out_valid && bus.out_ready) begin
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {bus.out_last, bus.out_data});
                            end else begin
                                chk("out_beat", {bus.out_last, bus.out_data}, exp_q.pop_front());
                            end
                        end
                        if (bus.in_valid && bus.in_ready && bus.in_last && cur_ok) pc_model++;
                        if (bus.out_valid && bus.out_ready && bus.out_last) pc_model--;
                        if (drop_pulse) drops++;
                        stall_prev = bus.out_valid && !bus.out_ready;
                        held = {bus.out_last, bus.out_data};
                    end
                end
            end
            begin : main
                // reset state
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("rst_in_ready", bus.in_ready, 0);
                chk("rst_out_valid", bus.out_valid, 0);
                chk("rst_out_data", bus.out_data, 0);
                chk("rst_out_last", bus.out_last, 0);
                chk("rst_mem_we", bus.mem_we, 0);
                chk("rst_mem_waddr", bus.mem_waddr, 0);
                chk("rst_mem_raddr", bus.mem_raddr, 0);
                chk("rst_pkt_count", pkt_count, 0);
                chk("rst_drop_pulse", drop_pulse, 0);
                rst_n = 1'b1;
                @(negedge clk);
                chk("post_rst_in_ready", bus.in_ready, 1);
                chk("post_rst_out_valid", bus.out_valid, 0);

                // table: latency and ordering of a single packet
                @(posedge clk);
                #1;
                for (int i = 0; i < 11; i++) begin
                    bus.in_valid  = tbl[i].iv;
                    bus.in_data   = tbl[i].id;
                    bus.in_last   = tbl[i].il;
                    bus.out_ready = tbl[i].ordy;
                    @(negedge clk);
                    chk("tbl_in_ready", bus.in_ready, tbl[i].e_irdy);
                    chk("tbl_mem_we", bus.mem_we, tbl[i].e_we);
                    chk("tbl_out_valid", bus.out_valid, tbl[i].e_ov);
                    chk("tbl_pkt_count", pkt_count, tbl[i].e_pc);
                    if (tbl[i].e_we) chk("tbl_mem_waddr", bus.mem_waddr, tbl[i].e_wa);
                    if (tbl[i].e_ov) chk("tbl_out_beat", {bus.out_last, bus.out_data}, {tbl[i].e_ol, tbl[i].e_od});
                    @(posedge clk);
                    #1;
                end
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                pc_model = 0;
                sb_en    = 1'b1;

                // two 3-beat packets held at the egress
                bus.out_ready = 1'b0;
                send_pkt(3, 32'h100, 1'b1, wa);
                send_pkt(3, 32'h200, 1'b1, wa);
                repeat (4) @(posedge clk);
                #1;
                chk("two_pkts_count", pkt_count, 2);
                chk("two_pkts_in_ready", bus.in_ready, 1);
                bus.out_ready = 1'b1;
                drain();

                // fill: 16 memory entries plus the two prefetched output slots
                bus.out_ready = 1'b0;
                send_pkt(8, 32'h300, 1'b1, wa);
                send_pkt(8, 32'h400, 1'b1, wa);
                chk("fill_count", pkt_count, 2);
                for (int i = 0; i < 3; i++) exp_q.push_back({(i == 2), 32'h500 + DW'(i)});
                cur_ok = 1'b1;
                send_beat(32'h500, 1'b0, wa);
                send_beat(32'h501, 1'b0, wa);
                bus.in_valid = 1'b1;
                bus.in_data  = 32'h502;
                bus.in_last  = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("full_in_ready", bus.in_ready, 0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
                @(negedge clk);
                chk("full_pop_valid", bus.out_valid, 1);
                chk("full_pop_cycle_in_ready", bus.in_ready, 0);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                chk("after_pop_in_ready", bus.in_ready, 1);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                chk("fill_count_3", pkt_count, 3);
                bus.out_ready = 1'b1;
                drain();

                // oversize: 19-beat packet into an empty FIFO
                d0 = drops;
                cur_ok = 1'b0;
                for (int i = 0; i < DEPTH; i++) send_beat(32'h600 + DW'(i), 1'b0, wa);
                chk("oversize_no_early_drop", drops - d0, 0);
                bus.in_valid = 1'b1;
                bus.in_data  = 32'h610;
                bus.in_last  = 1'b0;
                @(negedge clk);
                chk("oversize_drop_pulse", drop_pulse, 1);
                chk("oversize_in_ready", bus.in_ready, 0);
                @(posedge clk);
                #1;
                send_beat(32'h610, 1'b0, wa);
                send_beat(32'h611, 1'b0, wa);
                send_beat(32'h612, 1'b1, wa);
                repeat (6) @(posedge clk);
                #1;
                chk("oversize_drop_count", drops - d0, 1);
                chk("oversize_pkt_count", pkt_count, 0);
                send_pkt(2, 32'h700, 1'b1, wa);
                drain();

                // reset in the middle of a packet
                cur_ok = 1'b1;
                send_beat(32'h7a0, 1'b0, wa);
                send_beat(32'h7a1, 1'b0, wa);
                send_beat(32'h7a2, 1'b0, wa);
                sb_en = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("midrst_in_ready", bus.in_ready, 0);
                chk("midrst_out_valid", bus.out_valid, 0);
                chk("midrst_pkt_count", pkt_count, 0);
                @(negedge clk);
                rst_n = 1'b1;
                exp_q.delete();
                pc_model   = 0;
                stall_prev = 1'b0;
                sb_en      = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("midrst_quiet", bus.out_valid, 0);
                end
                @(posedge clk);
                #1;
                send_pkt(2, 32'h800, 1'b1, wa);
                drain();

                // randomized packets under random egress backpressure
                d0 = drops;
                fork
                    begin
                        for (int p = 0; p < 100; p++) begin
                            int g;
                            send_pkt($urandom_range(1, DEPTH), $urandom, 1'b1, wa);
                            g = $urandom_range(0, 2);
                            if (g > 0) begin
                                repeat (g) @(posedge clk);
                                #1;
                            end
                        end
                        rnd_done = 1'b1;
                    end
                    begin
                        while (!rnd_done) begin
                            @(posedge clk);
                            #1;
                            bus.out_ready = ($urandom_range(0, 3) != 0);
                        end
                    end
                join
                bus.out_ready = 1'b1;
                drain();
                chk("random_no_drops", drops - d0, 0);

`ifdef PKT_FIFO_ERR_DROP_EN
                // errored packet is discarded and its space reused
                d0 = drops;
                cur_ok = 1'b0;
                send_beat(32'h900, 1'b0, wa);
                send_beat(32'h901, 1'b0, wa2);
                bus.in_err = 1'b1;
                send_beat(32'h902, 1'b1, wa2);
                bus.in_err = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                chk("err_drop_count", drops - d0, 1);
                chk("err_pkt_count", pkt_count, 0);
                send_pkt(2, 32'h910, 1'b1, wa2);
                chk("err_addr_reuse", wa2, wa);
                drain();
`endif
                done = 1'b1;
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
